// File: rtl/lock_pkg.sv
// Shared state encoding and output-flag decode for the multi-attempt lock.
package lock_pkg;

  typedef enum logic [2:0] {
    UNLOCKED        = 3'd0,
    CREATE_PASSWORD = 3'd1,
    LOCKED          = 3'd2,
    ENTER_PASSWORD  = 3'd3,
    ERROR           = 3'd4,
    LOCKOUT         = 3'd5
  } lock_state_t;

  typedef struct packed {
    logic locked;
    logic error;
    logic cp_flag;
    logic ep_flag;
    logic lockout;
  } lock_flags_t;

  localparam lock_flags_t FLAGS_OFF      = '0;
  localparam lock_flags_t FLAGS_CREATE   = 5'b00100;
  localparam lock_flags_t FLAGS_LOCKED   = 5'b10000;
  localparam lock_flags_t FLAGS_ENTER    = 5'b10010;
  localparam lock_flags_t FLAGS_ERROR    = 5'b01000;
  localparam lock_flags_t FLAGS_LOCKOUT  = 5'b10001;

  function automatic lock_flags_t decode_flags(input lock_state_t s);
    case (s)
      CREATE_PASSWORD: decode_flags = FLAGS_CREATE;
      LOCKED:          decode_flags = FLAGS_LOCKED;
      ENTER_PASSWORD:  decode_flags = FLAGS_ENTER;
      ERROR:           decode_flags = FLAGS_ERROR;
      LOCKOUT:         decode_flags = FLAGS_LOCKOUT;
      default:         decode_flags = FLAGS_OFF;
    endcase
  endfunction

endpackage

// File: rtl/key_press_detector.sv
// Rising-from-idle detector: a press is a nonzero key following an all-zero key.
module key_press_detector #(
  parameter int KEY_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 press,
  output logic [KEY_WIDTH-1:0] digit
);

  logic [KEY_WIDTH-1:0] prev_key;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prev_key <= '0;
    else        prev_key <= key;
  end

  // Held keys and nonzero-to-nonzero changes never count as new presses.
  assign press = (key != '0) && (prev_key == '0);
  assign digit = key;

endmodule

// File: rtl/multi_attempt_lock.sv
// Password lock: create/confirm a password, unlock by entry, lockout after
// MAX_ATTEMPTS consecutive wrong entries.
module multi_attempt_lock
  import lock_pkg::*;
#(
  parameter int PASSWORD_LENGTH = 4,
  parameter int KEY_WIDTH       = 4,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int LOCKOUT_CYCLES  = 1000
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [KEY_WIDTH-1:0]                  key,
  output logic                                  locked,
  output logic                                  error,
  output logic                                  cp_flag,
  output logic                                  ep_flag,
  output logic                                  lockout,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     attempts_left,
  output logic [$clog2(2*PASSWORD_LENGTH+1)-1:0] digit_count
);

  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int DW = $clog2(2 * PASSWORD_LENGTH + 1);
  localparam int CW = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int BW = PASSWORD_LENGTH * KEY_WIDTH;

  localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_ATTEMPTS);
  localparam logic [DW-1:0] L_CNT    = DW'(PASSWORD_LENGTH);
  localparam logic [DW-1:0] L2_CNT   = DW'(2 * PASSWORD_LENGTH);
  localparam logic [CW-1:0] LOCK_LD  = CW'(LOCKOUT_CYCLES - 1);

  logic                 press;
  logic [KEY_WIDTH-1:0] digit;

  key_press_detector #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_detect (
    .clock(clock),
    .reset(reset),
    .key  (key),
    .press(press),
    .digit(digit)
  );

  // Reset release is retimed so the FSM first moves two edges after release.
  logic [1:0] run_pipe;
  logic       run;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) run_pipe <= '0;
    else        run_pipe <= {run_pipe[0], 1'b1};
  end

  assign run = run_pipe[1];

  lock_state_t       state, nxt_state;
  lock_flags_t       flags;
  logic [BW-1:0]     buf_a, buf_b, password;
  logic [BW-1:0]     nxt_a, nxt_b, nxt_pw, a_ins, b_ins;
  logic [AW-1:0]     nxt_att;
  logic [DW-1:0]     nxt_cnt;
  logic [CW-1:0]     lock_cnt, nxt_lock_cnt;
  logic              from_enter, nxt_from_enter;

  // Buffers with the current digit inserted at the slot digit_count selects.
  always_comb begin
    a_ins = buf_a;
    b_ins = buf_b;
    for (int unsigned i = 0; i < PASSWORD_LENGTH; i++) begin
      if (DW'(i) == digit_count)
        a_ins[i*KEY_WIDTH +: KEY_WIDTH] = digit;
      if (DW'(i) + L_CNT == digit_count)
        b_ins[i*KEY_WIDTH +: KEY_WIDTH] = digit;
    end
  end

  always_comb begin
    nxt_state      = state;
    nxt_cnt        = digit_count;
    nxt_att        = attempts_left;
    nxt_a          = buf_a;
    nxt_b          = buf_b;
    nxt_pw         = password;
    nxt_from_enter = from_enter;
    nxt_lock_cnt   = lock_cnt;
    if (run) begin
      case (state)
        UNLOCKED: begin
          if (press) begin
            nxt_state = CREATE_PASSWORD;
            nxt_cnt   = '0;
          end
        end
        CREATE_PASSWORD: begin
          if (press) begin
            if (digit_count < L_CNT) begin
              nxt_a   = a_ins;
              nxt_cnt = digit_count + 1'b1;
            end else if (digit_count == L2_CNT - 1'b1) begin
              nxt_b   = b_ins;
              nxt_cnt = '0;
              if (buf_a == b_ins) begin
                nxt_pw    = buf_a;
                nxt_state = LOCKED;
                nxt_att   = ATT_MAX;
              end else begin
                nxt_state      = ERROR;
                nxt_from_enter = 1'b0;
              end
            end else if (digit_count < L2_CNT) begin
              nxt_b   = b_ins;
              nxt_cnt = digit_count + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (press) begin
            nxt_state = ENTER_PASSWORD;
            nxt_cnt   = '0;
          end
        end
        ENTER_PASSWORD: begin
          if (press) begin
            nxt_a = a_ins;
            if (digit_count == L_CNT - 1'b1) begin
              nxt_cnt = '0;
              if (a_ins == password) begin
                nxt_state = UNLOCKED;
                nxt_att   = ATT_MAX;
              end else if (attempts_left <= AW'(1)) begin
                nxt_att      = '0;
                nxt_state    = LOCKOUT;
                nxt_lock_cnt = LOCK_LD;
              end else begin
                nxt_att        = attempts_left - 1'b1;
                nxt_state      = ERROR;
                nxt_from_enter = 1'b1;
              end
            end else if (digit_count < L2_CNT) begin
              nxt_cnt = digit_count + 1'b1;
            end
          end
        end
        ERROR: begin
          if (press) nxt_state = from_enter ? LOCKED : UNLOCKED;
        end
        LOCKOUT: begin
          if (lock_cnt == '0) begin
            nxt_state = LOCKED;
            nxt_att   = ATT_MAX;
          end else begin
            nxt_lock_cnt = lock_cnt - 1'b1;
          end
        end
        default: begin
          nxt_state = UNLOCKED;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= UNLOCKED;
      flags         <= FLAGS_OFF;
      digit_count   <= '0;
      attempts_left <= ATT_MAX;
      buf_a         <= '0;
      buf_b         <= '0;
      password      <= '0;
      lock_cnt      <= '0;
      from_enter    <= 1'b0;
    end else begin
      state         <= nxt_state;
      flags         <= decode_flags(nxt_state);
      digit_count   <= nxt_cnt;
      attempts_left <= nxt_att;
      buf_a         <= nxt_a;
      buf_b         <= nxt_b;
      password      <= nxt_pw;
      lock_cnt      <= nxt_lock_cnt;
      from_enter    <= nxt_from_enter;
    end
  end

  assign locked  = flags.locked;
  assign error   = flags.error;
  assign cp_flag = flags.cp_flag;
  assign ep_flag = flags.ep_flag;
  assign lockout = flags.lockout;

endmodule

// File: tb/tb_multi_attempt_lock.sv
// Directed bench for multi_attempt_lock with L=3, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=16.
module tb_multi_attempt_lock;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key   = 4'h0;
  logic       locked, error, cp_flag, ep_flag, lockout;
  logic [1:0] attempts_left;
  logic [2:0] digit_count;

  int tests = 0;
  int fails = 0;

  multi_attempt_lock #(
    .PASSWORD_LENGTH(3),
    .KEY_WIDTH      (4),
    .MAX_ATTEMPTS   (3),
    .LOCKOUT_CYCLES (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .key          (key),
    .locked       (locked),
    .error        (error),
    .cp_flag      (cp_flag),
    .ep_flag      (ep_flag),
    .lockout      (lockout),
    .attempts_left(attempts_left),
    .digit_count  (digit_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // flags packed as {locked,error,cp,ep,lockout}
  task automatic check_flags(input string tag, input logic [4:0] exp);
    check(tag, 32'({locked, error, cp_flag, ep_flag, lockout}), 32'(exp));
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge clock);
    key = d;
    @(negedge clock);
    key = 4'h0;
  endtask

  task automatic enter3(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
    press(d0);
    press(d1);
    press(d2);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clock);
    check_flags("reset_flags", 5'b00000);
    check("reset_att", 32'(attempts_left), 3);
    check("reset_dc", 32'(digit_count), 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Create password 2,3,4
    press(4'h1);
    check_flags("create_enter", 5'b00100);
    check("create_dc0", 32'(digit_count), 0);
    enter3(4'h2, 4'h3, 4'h4);
    check("create_dc3", 32'(digit_count), 3);
    press(4'h2);
    press(4'h3);
    check("create_dc5", 32'(digit_count), 5);
    press(4'h4);
    check_flags("create_locked", 5'b10000);
    check("create_att", 32'(attempts_left), 3);
    check("create_dc_clr", 32'(digit_count), 0);

    // One wrong entry, then back to LOCKED
    press(4'h9);
    check_flags("enter_ep", 5'b10010);
    press(4'h7);
    press(4'h7);
    check("enter_dc2", 32'(digit_count), 2);
    press(4'h7);
    check_flags("wrong1_error", 5'b01000);
    check("wrong1_att", 32'(attempts_left), 2);
    press(4'h5);
    check_flags("wrong1_back_locked", 5'b10000);

    // Correct entry restores attempts and unlocks
    press(4'h1);
    enter3(4'h2, 4'h3, 4'h4);
    check_flags("unlock_ok", 5'b00000);
    check("unlock_att", 32'(attempts_left), 3);

    // Mismatched confirmation
    press(4'h1);
    enter3(4'h1, 4'h2, 4'h3);
    enter3(4'h4, 4'h5, 4'h6);
    check_flags("mismatch_error", 5'b01000);
    check("mismatch_dc", 32'(digit_count), 0);
    press(4'h8);
    check_flags("mismatch_to_unlocked", 5'b00000);

    // Recreate 2,3,4 and drive three wrong entries
    press(4'h1);
    enter3(4'h2, 4'h3, 4'h4);
    enter3(4'h2, 4'h3, 4'h4);
    check_flags("recreate_locked", 5'b10000);
    press(4'h1);
    enter3(4'h7, 4'h7, 4'h7);
    press(4'h1);
    check_flags("wrong1b_locked", 5'b10000);
    press(4'h1);
    enter3(4'h7, 4'h7, 4'h7);
    check("wrong2_att", 32'(attempts_left), 1);
    press(4'h1);
    press(4'h1);
    enter3(4'h7, 4'h7, 4'h7);
    check_flags("lockout_enter", 5'b10001);
    check("lockout_att", 32'(attempts_left), 0);

    // Presses toggle during lockout; key held at F from cycle 13 across exit
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      check_flags($sformatf("lockout_hold_%0d", k), 5'b10001);
      key = (k < 13) ? ((k % 2 == 1) ? 4'hA : 4'h0) : 4'hF;
    end
    @(negedge clock);
    check_flags("lockout_exit", 5'b10000);
    check("lockout_exit_att", 32'(attempts_left), 3);
    repeat (2) @(negedge clock);
    check_flags("held_no_press", 5'b10000);
    key = 4'h0;
    @(negedge clock);
    press(4'h2);
    check_flags("post_lockout_ep", 5'b10010);
    enter3(4'h2, 4'h3, 4'h4);
    check_flags("post_lockout_unlock", 5'b00000);

    // Held key in UNLOCKED yields a single press
    @(negedge clock);
    key = 4'hF;
    repeat (5) @(negedge clock);
    check_flags("held_cp", 5'b00100);
    check("held_dc", 32'(digit_count), 0);
    key = 4'h0;
    @(negedge clock);
    check("held_dc_after", 32'(digit_count), 0);

    // Reset in the middle of an entry
    enter3(4'h2, 4'h3, 4'h4);
    enter3(4'h2, 4'h3, 4'h4);
    press(4'h1);
    press(4'h5);
    press(4'h6);
    check("mid_dc2", 32'(digit_count), 2);
    #2 reset = 1'b0;
    #1;
    check_flags("async_reset_flags", 5'b00000);
    check("async_reset_dc", 32'(digit_count), 0);
    check("async_reset_att", 32'(attempts_left), 3);
    @(negedge clock);
    reset = 1'b1;
    key   = 4'h5;
    @(negedge clock);
    check_flags("release_sync1", 5'b00000);
    @(negedge clock);
    check_flags("release_sync2", 5'b00000);
    key = 4'h0;
    repeat (2) @(negedge clock);
    press(4'h3);
    check_flags("after_reset_cp", 5'b00100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_attempt_lock.md
MULTI_ATTEMPT_LOCK -- requirements
Module: multi_attempt_lock

Interface
REQ-001 SHALL have parameter PASSWORD_LENGTH, default 4, digits per password (1..16).
REQ-002 SHALL have parameter KEY_WIDTH, default 4, number of push-button inputs; one digit is one KEY_WIDTH-bit value.
REQ-003 SHALL have parameter MAX_ATTEMPTS, default 3, consecutive wrong entries before lockout (1..15).
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 1000, lockout duration in clock cycles (>=2).
REQ-005 SHALL have port: clock  input  1  single system clock, all state on rising edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: key  input  KEY_WIDTH  push buttons, active-high, synchronous to clock.
REQ-008 SHALL have port: locked  output  1  high in LOCKED, ENTER_PASSWORD and LOCKOUT.
REQ-009 SHALL have port: error  output  1  high in ERROR only.
REQ-010 SHALL have port: cp_flag  output  1  high in CREATE_PASSWORD only.
REQ-011 SHALL have port: ep_flag  output  1  high in ENTER_PASSWORD only.
REQ-012 SHALL have port: lockout  output  1  high in LOCKOUT only.
REQ-013 SHALL have port: attempts_left  output  $clog2(MAX_ATTEMPTS+1)  wrong entries remaining before lockout.
REQ-014 SHALL have port: digit_count  output  $clog2(2*PASSWORD_LENGTH+1)  digits captured in current entry.

Function
REQ-015 Press event SHALL be key!=0 this cycle with key==0 in the previous cycle; digit = key; a held key or a nonzero-to-nonzero change SHALL give no press.
REQ-016 States SHALL be UNLOCKED, CREATE_PASSWORD, LOCKED, ENTER_PASSWORD, ERROR, LOCKOUT; all outputs registered; a transition SHALL be visible on the rising edge that samples the press (latency 1 clock).
REQ-017 UNLOCKED: press -> CREATE_PASSWORD, digit_count=0; the press SHALL NOT be captured as a digit.
REQ-018 CREATE_PASSWORD: presses 1..L SHALL fill buffer A, L+1..2L buffer B, digit_count incrementing per press.
REQ-019 On press 2L: A==B -> store A as password, LOCKED, attempts_left=MAX_ATTEMPTS; A!=B -> ERROR, password unchanged; digit_count=0.
REQ-020 LOCKED: press -> ENTER_PASSWORD, digit_count=0, press not captured.
REQ-021 ENTER_PASSWORD: on press L, match -> UNLOCKED, attempts_left=MAX_ATTEMPTS.
REQ-022 On mismatch: attempts_left decrements; if result is 0 -> LOCKOUT, else -> ERROR.
REQ-023 ERROR: press -> LOCKED if entered from ENTER_PASSWORD, else UNLOCKED (origin held in a 1-bit register).
REQ-024 LOCKOUT: key SHALL be ignored; a down-counter loaded with LOCKOUT_CYCLES-1 on entry SHALL reach 0 and then move to LOCKED with attempts_left=MAX_ATTEMPTS.
REQ-025 A key held through LOCKOUT exit SHALL NOT generate a press until released to 0.
REQ-026 digit_count SHALL saturate at 2L and never wrap; unused state encodings SHALL recover to UNLOCKED.

Reset
REQ-027 reset low SHALL asynchronously force UNLOCKED, all flags 0, digit_count 0, attempts_left MAX_ATTEMPTS, password and buffers 0, lockout counter 0, previous-key register 0.
REQ-028 Reset asserted mid-entry or mid-lockout SHALL discard all progress; release SHALL be synchronised so first state change occurs on a later rising edge.

Structure
REQ-029 State enumeration and flag-decode constants SHALL live in shared package lock_pkg.
REQ-030 Press detection SHALL be sub-module key_press_detector (previous-key register, press pulse, digit out).

Verification (L=3, KEY_WIDTH=4, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=16)
REQ-031 Reset, press 1, then 2,3,4,2,3,4 each separated by key=0 -> cp_flag after first press, locked=1 and attempts_left=3 after sixth digit.
REQ-032 In CREATE_PASSWORD enter 1,2,3,4,5,6 -> error=1, press -> UNLOCKED, all flags 0.
REQ-033 Locked with 2,3,4: press, enter 7,7,7 -> error=1, attempts_left=2; press -> locked=1, ep_flag=0.
REQ-034 Three wrong entries -> lockout=1, attempts_left=0; presses ignored; locked=1, lockout=0 exactly 16 cycles after entry; attempts_left=3.
REQ-035 Enter 2,3,4 -> UNLOCKED; key held at F for 5 cycles -> single press only, digit_count=0, cp_flag=1.
REQ-036 reset low after 2 digits in ENTER_PASSWORD -> immediately UNLOCKED, all outputs reset values.
